ro_freq_meter: RTL and testbench

- Measures the frequency of the ring-oscillator tap chosen by the per-group 16:1 output mux. Sits directly downstream of that mux.
- Counts rising edges of the selected, externally pre-divided oscillator signal over a programmable window of system-clock cycles.
- Drives the oscillator `start` enable for the duration of a measurement.
- Returns a saturating edge count with an overflow flag and a one-cycle done pulse.

---
 rtl/ro_meas_pkg.sv | 26 ++
 rtl/ro_sync_edge_det.sv | 35 +++
 rtl/ro_freq_meter.sv | 159 +++++++++++++++
 tb/tb_ro_freq_meter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg
// Shared types and constants for the ring-oscillator frequency meter.
//   - meas_state_e : measurement FSM states
//   - *_DEF        : default parameter values for the meter and its synchronizer
//   - arm_cycles() : length of the ARM phase for a given synchronizer depth
package ro_meas_pkg;

    localparam int CNT_W_DEF       = 24;
    localparam int WIN_W_DEF       = 20;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } meas_state_e;

    // ARM has to cover every synchronizer flop plus the history flop so that
    // the level captured before the oscillator was enabled cannot produce a
    // spurious edge once counting starts.
    function automatic int arm_cycles(input int syncStages);
        return syncStages + 1;
    endfunction

endpackage

// File: rtl/ro_sync_edge_det.sv
// ro_sync_edge_det
// Brings the asynchronous oscillator signal into the clk_i domain and flags
// its rising edges.
// Ports:
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   async_i  : asynchronous input level (SYNC_STAGES must be 2..4)
//   rise_o   : one-cycle pulse per synchronized rising edge
module ro_sync_edge_det
    import ro_meas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter
// Counts rising edges of the selected (pre-divided) ring-oscillator output
// over a programmable number of wb_clk_i cycles.
// Ports:
//   wb_clk_i    : system clock
//   wb_rst_n_i  : asynchronous active-low reset
//   ro_in_i     : selected oscillator output, asynchronous
//   start_i     : single-cycle measurement request (ignored while busy)
//   abort_i     : cancel a measurement in ARM or COUNT
//   window_i    : window length in wb_clk_i cycles, sampled on start
//   ro_start_o  : oscillator enable, high during ARM and COUNT
//   busy_o      : high whenever the FSM is not IDLE
//   done_o      : one-cycle pulse when count_o/ovf_o are updated
//   count_o     : last completed (saturating) edge count
//   ovf_o       : last completed measurement saturated
module ro_freq_meter
    import ro_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             ro_in_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIN_W-1:0] window_i,
    output logic             ro_start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    localparam int ARM_CYC = arm_cycles(SYNC_STAGES);

    meas_state_e      state_q, state_d;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] winCnt_q, winCnt_d;
    logic [CNT_W-1:0] edgeCnt_q, edgeCnt_d;
    logic             ovfInt_q, ovfInt_d;
    logic [2:0]       armCnt_q, armCnt_d;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             winLatch;
    logic             loadResult;
    logic             rise;

    ro_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .async_i (ro_in_i),
        .rise_o  (rise)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= IDLE;
            win_q     <= '0;
            winCnt_q  <= '0;
            edgeCnt_q <= '0;
            ovfInt_q  <= 1'b0;
            armCnt_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            winCnt_q  <= winCnt_d;
            edgeCnt_q <= edgeCnt_d;
            ovfInt_q  <= ovfInt_d;
            armCnt_q  <= armCnt_d;
            if (winLatch) begin
                win_q <= window_i;
            end
            // The result is captured on the edge that enters DONE, using the
            // next-state count so the final COUNT cycle's edge is included.
            if (loadResult) begin
                count_q <= edgeCnt_d;
                ovf_q   <= ovfInt_d;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        winCnt_d   = winCnt_q;
        edgeCnt_d  = edgeCnt_q;
        ovfInt_d   = ovfInt_q;
        armCnt_d   = armCnt_q;
        winLatch   = 1'b0;
        loadResult = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    winLatch  = 1'b1;
                    edgeCnt_d = '0;
                    ovfInt_d  = 1'b0;
                    armCnt_d  = '0;
                    state_d   = ARM;
                end
            end

            ARM: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (armCnt_q == 3'(ARM_CYC - 1)) begin
                    if (win_q == '0) begin
                        state_d    = DONE;
                        loadResult = 1'b1;
                    end else begin
                        state_d  = COUNT;
                        winCnt_d = win_q;
                    end
                end else begin
                    armCnt_d = armCnt_q + 3'd1;
                end
            end

            COUNT: begin
                // Saturate at all-ones; an edge arriving at saturation marks overflow.
                if (rise) begin
                    if (edgeCnt_q == '1) begin
                        ovfInt_d = 1'b1;
                    end else begin
                        edgeCnt_d = edgeCnt_q + CNT_W'(1);
                    end
                end
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    winCnt_d = winCnt_q - WIN_W'(1);
                    if (winCnt_q == WIN_W'(1)) begin
                        state_d    = DONE;
                        loadResult = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ro_start_o = (state_q == ARM) || (state_q == COUNT);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign count_o    = count_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter
// Directed bench for ro_freq_meter. A default-width instance and a CNT_W=4
// instance share all inputs; the narrow one is used for saturation cases.
module tb_ro_freq_meter;

    logic        clk      = 1'b0;
    logic        rstN     = 1'b0;
    logic        roIn     = 1'b0;
    logic        startIn  = 1'b0;
    logic        abortIn  = 1'b0;
    logic [19:0] windowIn = '0;

    logic        roStart, busy, done, ovf;
    logic [23:0] countOut;
    logic        roStart4, busy4, done4, ovf4;
    logic [3:0]  count4;

    int checkCount = 0;
    int failCount  = 0;
    int roHalfNs   = 40;
    bit roEn       = 1'b0;

    int  doneAt, roHigh, doneCnt;
    logic roAfter;

    ro_freq_meter dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rstN),
        .ro_in_i    (roIn),
        .start_i    (startIn),
        .abort_i    (abortIn),
        .window_i   (windowIn),
        .ro_start_o (roStart),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (countOut),
        .ovf_o      (ovf)
    );

    ro_freq_meter #(.CNT_W(4)) dut4 (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rstN),
        .ro_in_i    (roIn),
        .start_i    (startIn),
        .abort_i    (abortIn),
        .window_i   (windowIn),
        .ro_start_o (roStart4),
        .busy_o     (busy4),
        .done_o     (done4),
        .count_o    (count4),
        .ovf_o      (ovf4)
    );

    always #5 clk = ~clk;

    // Oscillator model, offset from the clock so it never toggles on an edge.
    initial begin
        #3;
        forever begin
            #(roHalfNs);
            if (roEn) roIn = ~roIn;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic [19:0] w);
        startIn  = s;
        abortIn  = a;
        windowIn = w;
    endtask

    // Pulses start, then watches maxCyc cycles. k=1 is the cycle after the
    // start-accepting edge. extraA/extraB inject start pulses, abortAt an abort.
    task automatic runMeas(input int win, input int maxCyc, input int extraA,
                           input int extraB, input int abortAt);
        doneAt  = 0;
        roHigh  = 0;
        doneCnt = 0;
        roAfter = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'(win));
        for (int k = 1; k <= maxCyc; k++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                if (doneAt == 0) doneAt = k;
            end
            if (roStart && doneCnt == 0) roHigh++;
            if (abortAt != 0 && k == abortAt + 1) roAfter = roStart;
            applyStimulus((k == extraA) || (k == extraB), (abortAt != 0) && (k == abortAt), 20'd5);
        end
        applyStimulus(1'b0, 1'b0, 20'd0);
    endtask

    initial begin
        #23;
        checkOutput("rst_ro_start", roStart, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_count", countOut, 0);
        checkOutput("rst_ovf", ovf, 0);
        @(negedge clk);
        rstN = 1'b1;
        roEn = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] basic count, window 800, period 8");
        runMeas(800, 900, 0, 0, 0);
        checkOutput("basic_latency", doneAt, 804);
        checkOutput("basic_ro_high", roHigh, 803);
        checkOutput("basic_done_cnt", doneCnt, 1);
        checkOutput("basic_count_range", (countOut >= 24'd99 && countOut <= 24'd101), 1);
        checkOutput("basic_ovf", ovf, 0);
        checkOutput("basic_idle", busy, 0);

        $display("[TB] zero window");
        runMeas(0, 20, 0, 0, 0);
        checkOutput("zero_latency", doneAt, 4);
        checkOutput("zero_ro_high", roHigh, 3);
        checkOutput("zero_count", countOut, 0);
        checkOutput("zero_ovf", ovf, 0);

        $display("[TB] saturation, period 4");
        roHalfNs = 20;
        repeat (20) @(negedge clk);
        runMeas(200, 250, 0, 0, 0);
        checkOutput("sat_count4", count4, 15);
        checkOutput("sat_ovf4", ovf4, 1);
        checkOutput("sat_count24", countOut, 50);
        checkOutput("sat_ovf24", ovf, 0);
        runMeas(8, 30, 0, 0, 0);
        checkOutput("post_sat_count4", count4, 2);
        checkOutput("post_sat_ovf4", ovf4, 0);
        checkOutput("post_sat_latency", doneAt, 12);

        $display("[TB] abort");
        roHalfNs = 40;
        repeat (20) @(negedge clk);
        runMeas(56, 100, 0, 0, 0);
        checkOutput("pre_abort_count", countOut, 7);
        runMeas(1000, 51, 0, 0, 50);
        checkOutput("abort_no_done", doneCnt, 0);
        checkOutput("abort_ro_start", roAfter, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_count_held", countOut, 7);
        runMeas(0, 20, 0, 0, 0);
        checkOutput("after_abort_latency", doneAt, 4);

        $display("[TB] busy rejection");
        runMeas(100, 250, 10, 20, 0);
        checkOutput("busy_done_cnt", doneCnt, 1);
        checkOutput("busy_latency", doneAt, 104);
        checkOutput("busy_count_range", (countOut >= 24'd12 && countOut <= 24'd13), 1);

        $display("[TB] async reset mid-count");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'd100);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'd5);
        repeat (20) @(negedge clk);
        checkOutput("pre_rst_busy", busy, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("arst_ro_start", roStart, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        checkOutput("arst_count", countOut, 0);
        checkOutput("arst_ovf", ovf, 0);
        @(negedge clk);
        rstN = 1'b1;
        doneCnt = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("arst_no_done", doneCnt, 0);
        checkOutput("arst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
